// File: rtl/cp_gen_pkg.sv
// Shared encodings for the cp_gen control-signal generator: opcode constants,
// control-field encodings and the packed control word passed from the
// combinational decoder to the output register.
package cp_gen_pkg;

  // Instruction opcodes (10-bit field)
  localparam logic [9:0] OP_AND_REG = 10'b0100000000;
  localparam logic [9:0] OP_EOR_REG = 10'b0100000001;
  localparam logic [9:0] OP_ORR_REG = 10'b0100001100;
  localparam logic [9:0] OP_ADD_REG = 10'b0000001100;
  localparam logic [9:0] OP_ADD_IMM = 10'b0000001110;
  localparam logic [9:0] OP_SUB_REG = 10'b0000000100;
  localparam logic [9:0] OP_SUB_IMM = 10'b0000000110;
  localparam logic [9:0] OP_LDR_IMM = 10'b0000001101;
  localparam logic [9:0] OP_STR_IMM = 10'b0000001111;
  localparam logic [9:0] OP_B_AL    = 10'b0000011110;
  localparam logic [9:0] OP_BX      = 10'b0000011111;

  // Conditional branches share the upper six bits; the low nibble is the condition
  localparam logic [5:0] OP_BCOND_PFX = 6'b000001;

  // Condition codes (ARM encoding)
  localparam logic [3:0] COND_AL        = 4'b1110;
  localparam logic [3:0] COND_BCOND_MAX = 4'b1101;

  // ALU operations
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_EOR = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_ORR = 4'b1100;

  // Immediate format select (one bit per format, zero means no immediate)
  localparam logic [3:0] IMM_NONE  = 4'b0000;
  localparam logic [3:0] IMM_ALU   = 4'b0001;
  localparam logic [3:0] IMM_MEM   = 4'b0010;
  localparam logic [3:0] IMM_BCOND = 4'b0100;
  localparam logic [3:0] IMM_BUNC  = 4'b1000;

  // Register-use select: [0] Rn read, [1] Rm read, [2] Rd write, [3] Rt store read
  localparam logic [3:0] REG_NONE   = 4'b0000;
  localparam logic [3:0] REG_RN     = 4'b0001;
  localparam logic [3:0] REG_RN_RD  = 4'b0101;
  localparam logic [3:0] REG_3OP    = 4'b0111;
  localparam logic [3:0] REG_STORE  = 4'b1001;

  // Flag write enables, [3]=N [2]=Z [1]=C [0]=V
  localparam logic [3:0] NZCV_NONE  = 4'b0000;
  localparam logic [3:0] NZCV_LOGIC = 4'b1100;
  localparam logic [3:0] NZCV_ARITH = 4'b1111;

  // Complete set of datapath controls produced for one opcode
  typedef struct packed {
    logic [3:0] regsel;
    logic [3:0] immsel;
    logic [3:0] nzcvwrite;
    logic       r_branch;
    logic [3:0] cond;
    logic       memrw;
    logic       memtoreg;
    logic [3:0] aluop;
    logic       alusrc;
    logic       regwrite;
    logic       bsel;
    logic       c_branch;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  // Control word for a register-writing data-processing instruction
  function automatic ctrl_t ctrl_dp(input logic [3:0] regsel,
                                    input logic [3:0] immsel,
                                    input logic       alusrc,
                                    input logic [3:0] aluop,
                                    input logic [3:0] nzcv);
    ctrl_t c;
    c           = '0;
    c.regsel    = regsel;
    c.immsel    = immsel;
    c.alusrc    = alusrc;
    c.aluop     = aluop;
    c.nzcvwrite = nzcv;
    c.regwrite  = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/cp_gen_decode.sv
// Purely combinational opcode decoder: maps the 10-bit opcode to a full
// control word. Unrecognised opcodes yield an all-zero word (NOP) so they
// cannot cause register, memory, flag or PC side effects.
module cp_gen_decode
  import cp_gen_pkg::*;
(
  input  logic [9:0] opcode,
  output ctrl_t      ctrl
);

  // Opcode to control-word lookup; everything not set stays zero
  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_AND_REG: ctrl = ctrl_dp(REG_3OP,   IMM_NONE, 1'b0, ALU_AND, NZCV_LOGIC);
      OP_EOR_REG: ctrl = ctrl_dp(REG_3OP,   IMM_NONE, 1'b0, ALU_EOR, NZCV_LOGIC);
      OP_ORR_REG: ctrl = ctrl_dp(REG_3OP,   IMM_NONE, 1'b0, ALU_ORR, NZCV_LOGIC);
      OP_ADD_REG: ctrl = ctrl_dp(REG_3OP,   IMM_NONE, 1'b0, ALU_ADD, NZCV_ARITH);
      OP_ADD_IMM: ctrl = ctrl_dp(REG_RN_RD, IMM_ALU,  1'b1, ALU_ADD, NZCV_ARITH);
      OP_SUB_REG: ctrl = ctrl_dp(REG_3OP,   IMM_NONE, 1'b0, ALU_SUB, NZCV_ARITH);
      OP_SUB_IMM: ctrl = ctrl_dp(REG_RN_RD, IMM_ALU,  1'b1, ALU_SUB, NZCV_ARITH);
      OP_LDR_IMM: begin
        // Load: address = Rn + offset, write-back comes from memory, flags untouched
        ctrl          = ctrl_dp(REG_RN_RD, IMM_MEM, 1'b1, ALU_ADD, NZCV_NONE);
        ctrl.memtoreg = 1'b1;
      end
      OP_STR_IMM: begin
        // Store: address = Rn + offset, Rt supplies data, no register write
        ctrl.regsel = REG_STORE;
        ctrl.immsel = IMM_MEM;
        ctrl.alusrc = 1'b1;
        ctrl.aluop  = ALU_ADD;
        ctrl.memrw  = 1'b1;
      end
      OP_B_AL: begin
        ctrl.immsel   = IMM_BUNC;
        ctrl.c_branch = 1'b1;
        ctrl.cond     = COND_AL;
      end
      OP_BX: begin
        // Register branch: target comes from Rn, always taken
        ctrl.regsel   = REG_RN;
        ctrl.r_branch = 1'b1;
        ctrl.bsel     = 1'b1;
        ctrl.cond     = COND_AL;
      end
      default: begin
        // Conditional branch family: condition nibble passed straight through.
        // Nibbles 1110/1111 are B.AL and BX, already matched above.
        if ((opcode[9:4] == OP_BCOND_PFX) && (opcode[3:0] <= COND_BCOND_MAX)) begin
          ctrl.immsel   = IMM_BCOND;
          ctrl.c_branch = 1'b1;
          ctrl.cond     = opcode[3:0];
        end else begin
          ctrl = '0;
        end
      end
    endcase
  end

endmodule

// File: rtl/cp_gen.sv
// Main control-signal generator. Decodes OPCODE combinationally and registers
// the whole control word in one flop bank, so every output changes together
// one clock after the opcode and never mixes fields from two instructions.
module cp_gen
  import cp_gen_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic [9:0] OPCODE,
  output logic [3:0] REGSEL,
  output logic [3:0] IMMSEL,
  output logic [3:0] NZCVWRITE,
  output logic       R_BRANCH,
  output logic [3:0] COND,
  output logic       MEMRW,
  output logic       MEMTOREG,
  output logic [3:0] ALUOP,
  output logic       ALUSRC,
  output logic       REGWRITE,
  output logic       BSEL,
  output logic       C_BRANCH
);

  ctrl_t dec_ctrl;
  ctrl_t ctrl_d;
  ctrl_t ctrl_q;

  cp_gen_decode u_decode (
    .opcode (OPCODE),
    .ctrl   (dec_ctrl)
  );

  // Next value of the output register is simply the current decode
  always_comb begin
    ctrl_d = dec_ctrl;
  end

  // Output register; reset clears every control to the safe all-zero state at once
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign REGSEL    = ctrl_q.regsel;
  assign IMMSEL    = ctrl_q.immsel;
  assign NZCVWRITE = ctrl_q.nzcvwrite;
  assign R_BRANCH  = ctrl_q.r_branch;
  assign COND      = ctrl_q.cond;
  assign MEMRW     = ctrl_q.memrw;
  assign MEMTOREG  = ctrl_q.memtoreg;
  assign ALUOP     = ctrl_q.aluop;
  assign ALUSRC    = ctrl_q.alusrc;
  assign REGWRITE  = ctrl_q.regwrite;
  assign BSEL      = ctrl_q.bsel;
  assign C_BRANCH  = ctrl_q.c_branch;

endmodule

// File: tb/tb_cp_gen.sv
// Self-checking bench for cp_gen: directed steps from the decode table plus
// random opcodes, compared against a table-driven reference model.
module tb_cp_gen;

  logic       CLK = 1'b0;
  logic       RST;
  logic [9:0] OPCODE;
  logic [3:0] REGSEL, IMMSEL, NZCVWRITE, COND, ALUOP;
  logic       R_BRANCH, MEMRW, MEMTOREG, ALUSRC, REGWRITE, BSEL, C_BRANCH;

  int total = 0;
  int bad   = 0;

  cp_gen dut (
    .CLK(CLK), .RST(RST), .OPCODE(OPCODE),
    .REGSEL(REGSEL), .IMMSEL(IMMSEL), .NZCVWRITE(NZCVWRITE),
    .R_BRANCH(R_BRANCH), .COND(COND), .MEMRW(MEMRW), .MEMTOREG(MEMTOREG),
    .ALUOP(ALUOP), .ALUSRC(ALUSRC), .REGWRITE(REGWRITE), .BSEL(BSEL),
    .C_BRANCH(C_BRANCH)
  );

  always #5 CLK = ~CLK;

  // Observed outputs in a fixed bench-side order
  logic [26:0] obs;
  assign obs = {REGSEL, IMMSEL, NZCVWRITE, R_BRANCH, COND, MEMRW, MEMTOREG,
                ALUOP, ALUSRC, REGWRITE, BSEL, C_BRANCH};

  function automatic logic [26:0] vec(input logic [3:0] regsel, input logic [3:0] immsel,
                                      input logic [3:0] nzcv, input logic rbr,
                                      input logic [3:0] cond, input logic memrw,
                                      input logic m2r, input logic [3:0] aluop,
                                      input logic alusrc, input logic regw,
                                      input logic bsel, input logic cbr);
    return {regsel, immsel, nzcv, rbr, cond, memrw, m2r, aluop, alusrc, regw, bsel, cbr};
  endfunction

  // Reference model: one row per instruction of the decode table, conditional
  // branches by numeric range (opcodes 16..29 carry condition op-16)
  function automatic logic [26:0] model(input logic [9:0] op);
    int v;
    v = int'(op);
    case (v)
      256: return vec(4'b0111, 4'b0000, 4'b1100, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
      257: return vec(4'b0111, 4'b0000, 4'b1100, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0);
      268: return vec(4'b0111, 4'b0000, 4'b1100, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b1100, 1'b0, 1'b1, 1'b0, 1'b0);
      12:  return vec(4'b0111, 4'b0000, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b0);
      14:  return vec(4'b0101, 4'b0001, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b1, 1'b0, 1'b0);
      4:   return vec(4'b0111, 4'b0000, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0);
      6:   return vec(4'b0101, 4'b0001, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b1, 1'b0, 1'b0);
      13:  return vec(4'b0101, 4'b0010, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0100, 1'b1, 1'b1, 1'b0, 1'b0);
      15:  return vec(4'b1001, 4'b0010, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0);
      30:  return vec(4'b0000, 4'b1000, 4'b0000, 1'b0, 4'b1110, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
      31:  return vec(4'b0001, 4'b0000, 4'b0000, 1'b1, 4'b1110, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
      default: begin
        if (v >= 16 && v <= 29)
          return vec(4'b0000, 4'b0100, 4'b0000, 1'b0, 4'(v - 16), 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        else
          return 27'd0;
      end
    endcase
  endfunction

  logic [26:0] prev_exp;
  logic [9:0]  legal [0:11];

  task automatic check(input string tag, input logic [26:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Structural invariants on whatever is currently registered
  task automatic check_inv(input string tag);
    logic ok;
    ok = !(MEMRW && REGWRITE) && !(R_BRANCH && C_BRANCH) && (!MEMTOREG || REGWRITE);
    total++;
    assert (ok === 1'b1)
    else begin
      bad++;
      $error("FAIL %s_inv observed=%b expected=1", tag, ok);
    end
  endtask

  // Apply op just after an edge: outputs must hold the previous decode until
  // the next edge, then show the new decode
  task automatic step(input logic [9:0] op, input string tag);
    OPCODE = op;
    #1;
    check({tag, "_hold"}, prev_exp);
    @(posedge CLK);
    #1;
    prev_exp = model(op);
    check(tag, prev_exp);
    check_inv(tag);
  endtask

  initial begin
    legal = '{10'b0100000000, 10'b0100000001, 10'b0100001100, 10'b0000001100,
              10'b0000001110, 10'b0000000100, 10'b0000000110, 10'b0000001101,
              10'b0000001111, 10'b0000011110, 10'b0000011111, 10'b0000010101};

    // Reset with a live opcode: outputs zero before and across a clock edge
    RST    = 1'b1;
    OPCODE = 10'b0000001100;
    #3;
    check("reset_immediate", 27'd0);
    @(posedge CLK);
    #1;
    check("reset_held", 27'd0);
    RST      = 1'b0;
    prev_exp = 27'd0;

    // First decode after reset, checked against a hand-written value too
    step(10'b0100000000, "and_reg");
    check("and_reg_literal",
          vec(4'b0111, 4'b0000, 4'b1100, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0));

    step(10'b0100001100, "orr_reg");
    step(10'b0100000001, "eor_reg");
    step(10'b0000001110, "add_imm");
    step(10'b0000001100, "add_reg");
    step(10'b0000001101, "ldr_imm");
    step(10'b0000001111, "str_imm");
    step(10'b0000010000, "b_eq");
    step(10'b0000011100, "b_cond_max");
    step(10'b0000011110, "b_al");
    step(10'b0000011111, "bx");
    step(10'b1111111111, "illegal");
    step(10'b0000000100, "sub_reg");
    step(10'b0000000110, "sub_imm");
    step(10'b0000000000, "zero_op");

    // Async clear mid-stream while ADD.reg is registered
    step(10'b0000001100, "add_before_rst");
    #2;
    RST = 1'b1;
    #1;
    check("async_clear", 27'd0);
    @(posedge CLK);
    #1;
    check("async_clear_held", 27'd0);
    RST      = 1'b0;
    prev_exp = 27'd0;

    // Random opcodes biased toward the decoded regions
    for (int i = 0; i < 300; i++) begin
      logic [9:0] op;
      case ($urandom_range(0, 3))
        0:       op = 10'($urandom_range(0, 1023));
        1:       op = 10'(16 + $urandom_range(0, 15));
        2:       op = legal[$urandom_range(0, 11)];
        default: op = 10'(256 + $urandom_range(0, 15));
      endcase
      step(op, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
